// File: rtl/boundary_arbiter.sv
// rtl/boundary_arbiter.sv - two-requester arbiter feeding a clock-boundary flit FIFO
//
// Purpose: arbitrates between two flit requesters (round-robin, or fixed
// priority to requester 0 when BOUNDARY_ARB_FIXED_PRIO_EN is defined) and
// buffers accepted flits in a DEPTH-entry FIFO whose head drives the
// clock-boundary port.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   req0_flit  requester 0 flit, bit WIDTH-1 is the request/valid bit
//   req0_ack   requester 0 flit accepted this cycle
//   req1_flit  requester 1 flit, bit WIDTH-1 is the request/valid bit
//   req1_ack   requester 1 flit accepted this cycle
//   bnd_flit   head-of-FIFO flit, all-zero when the FIFO is empty
//   bnd_ready  boundary port consumes bnd_flit this cycle
//   occupancy  current FIFO entry count
//
// Configuration macro: BOUNDARY_ARB_FIXED_PRIO_EN (requester 0 always wins).

module boundary_arbiter #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req0_flit,
    output logic                     req0_ack,
    input  logic [WIDTH-1:0]         req1_flit,
    output logic                     req1_ack,
    output logic [WIDTH-1:0]         bnd_flit,
    input  logic                     bnd_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             last_grant;

    logic             full;
    logic             empty;
    logic             v0;
    logic             v1;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_flit;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign v0    = req0_flit[WIDTH-1];
    assign v1    = req1_flit[WIDTH-1];

    // Acks are gated by rst so nothing is accepted while reset is held.
    // A full FIFO refuses acks even when a pop frees an entry this cycle.
    always_comb begin
        req0_ack = 1'b0;
        req1_ack = 1'b0;
        if (rst && !full) begin
            if (v0 && v1) begin
`ifdef BOUNDARY_ARB_FIXED_PRIO_EN
                req0_ack = 1'b1;
`else
                if (last_grant) begin
                    req0_ack = 1'b1;
                end else begin
                    req1_ack = 1'b1;
                end
`endif
            end else if (v0) begin
                req0_ack = 1'b1;
            end else if (v1) begin
                req1_ack = 1'b1;
            end
        end
    end

    assign push      = req0_ack | req1_ack;
    assign pop       = rst && !empty && bnd_ready;
    assign push_flit = req1_ack ? req1_flit : req0_flit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= req1_ack;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_flit;
        end
    end

    assign bnd_flit  = (rst && !empty) ? mem[rd_ptr] : '0;
    assign occupancy = count;

endmodule

// File: tb/tb_boundary_arbiter.sv
// tb/tb_boundary_arbiter.sv - scoreboard testbench for boundary_arbiter

module tb_boundary_arbiter;

    localparam int WIDTH = 144;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] req0_flit;
    logic             req0_ack;
    logic [WIDTH-1:0] req1_flit;
    logic             req1_ack;
    logic [WIDTH-1:0] bnd_flit;
    logic             bnd_ready;
    logic [2:0]       occupancy;

    boundary_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_flit (req0_flit),
        .req0_ack  (req0_ack),
        .req1_flit (req1_flit),
        .req1_ack  (req1_ack),
        .bnd_flit  (bnd_flit),
        .bnd_ready (bnd_ready),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] exp_q [$];
    logic             m_lg;
    logic             e_a0;
    logic             e_a1;
    logic [WIDTH-1:0] e_flit;
    logic [2:0]       e_occ;

    function automatic logic [WIDTH-1:0] mkflit(input logic v, input logic [31:0] tag);
        logic [WIDTH-1:0] f;
        f = '0;
        f[WIDTH-1] = v;
        f[31:0] = tag;
        f[95:64] = ~tag;
        return f;
    endfunction

    // Drive inputs just after a rising edge, then compute expected outputs at the falling edge.
    task automatic drive(input logic [WIDTH-1:0] f0, input logic [WIDTH-1:0] f1, input logic rdy);
        logic both;
        req0_flit = f0;
        req1_flit = f1;
        bnd_ready = rdy;
        @(negedge clk);
        e_a0 = 1'b0;
        e_a1 = 1'b0;
        if (exp_q.size() < DEPTH) begin
            both = f0[WIDTH-1] && f1[WIDTH-1];
`ifdef BOUNDARY_ARB_FIXED_PRIO_EN
            if (f0[WIDTH-1]) e_a0 = 1'b1;
            else if (f1[WIDTH-1]) e_a1 = 1'b1;
`else
            if (both) begin
                if (m_lg == 1'b1) e_a0 = 1'b1;
                else e_a1 = 1'b1;
            end else if (f0[WIDTH-1]) e_a0 = 1'b1;
            else if (f1[WIDTH-1]) e_a1 = 1'b1;
`endif
        end
        e_flit = (exp_q.size() > 0) ? exp_q[0] : '0;
        e_occ  = 3'(exp_q.size());
    endtask

    // Advance the scoreboard across the rising edge.
    task automatic commit();
        @(posedge clk);
        if (exp_q.size() > 0 && bnd_ready) void'(exp_q.pop_front());
        if (e_a0) begin
            exp_q.push_back(req0_flit);
            m_lg = 1'b0;
        end else if (e_a1) begin
            exp_q.push_back(req1_flit);
            m_lg = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        req0_flit = '0;
        req1_flit = '0;
        bnd_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_lg = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_flit = mkflit(1'b1, 32'h11);
        req1_flit = mkflit(1'b1, 32'h22);
        bnd_ready = 1'b1;
        #2;
        n_cmp++; if (req0_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack0 got=%b exp=0", req0_ack); end
        n_cmp++; if (req1_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack1 got=%b exp=0", req1_ack); end
        n_cmp++; if (bnd_flit !== '0) begin n_err++; $display("FAIL reset_flit got=%h exp=0", bnd_flit); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] f;
        f = 144'h8000_0123456789abcdef_0123456789abcdef;
        for (int c = 0; c < 3; c++) begin
            drive((c == 0) ? f : '0, '0, 1'b1);
            n_cmp++; if (req0_ack !== e_a0) begin n_err++; $display("FAIL single_ack0 c=%0d got=%b exp=%b", c, req0_ack, e_a0); end
            n_cmp++; if (req1_ack !== e_a1) begin n_err++; $display("FAIL single_ack1 c=%0d got=%b exp=%b", c, req1_ack, e_a1); end
            n_cmp++; if (bnd_flit !== e_flit) begin n_err++; $display("FAIL single_flit c=%0d got=%h exp=%h", c, bnd_flit, e_flit); end
            n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL single_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
            if (c == 1) begin
                n_cmp++; if (bnd_flit !== f) begin n_err++; $display("FAIL single_latency got=%h exp=%h", bnd_flit, f); end
            end
            commit();
        end
    endtask

    task automatic test_round_robin();
        logic want0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(mkflit(1'b1, 32'h100 + c), mkflit(1'b1, 32'h200 + c), 1'b1);
`ifdef BOUNDARY_ARB_FIXED_PRIO_EN
            want0 = 1'b1;
`else
            want0 = (c % 2 == 0);
`endif
            n_cmp++; if (req0_ack !== want0) begin n_err++; $display("FAIL rr_seq0 c=%0d got=%b exp=%b", c, req0_ack, want0); end
            n_cmp++; if (req1_ack !== !want0) begin n_err++; $display("FAIL rr_seq1 c=%0d got=%b exp=%b", c, req1_ack, !want0); end
            n_cmp++; if (bnd_flit !== e_flit) begin n_err++; $display("FAIL rr_flit c=%0d got=%h exp=%h", c, bnd_flit, e_flit); end
            n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL rr_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
            commit();
        end
    endtask

    task automatic test_full();
        int acks;
        do_reset();
        acks = 0;
        for (int c = 0; c < 14; c++) begin
            drive((c < 12) ? mkflit(1'b1, 32'h300 + c) : '0, '0, (c >= 6));
            if (req0_ack) acks++;
            n_cmp++; if (req0_ack !== e_a0) begin n_err++; $display("FAIL full_ack0 c=%0d got=%b exp=%b", c, req0_ack, e_a0); end
            n_cmp++; if (bnd_flit !== e_flit) begin n_err++; $display("FAIL full_flit c=%0d got=%h exp=%h", c, bnd_flit, e_flit); end
            n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL full_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
            if (c == 6) begin
                n_cmp++; if (acks !== 4) begin n_err++; $display("FAIL full_ack_count got=%0d exp=4", acks); end
                n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ4 got=%0d exp=4", occupancy); end
                n_cmp++; if (req0_ack !== 1'b0) begin n_err++; $display("FAIL full_pop_noack got=%b exp=0", req0_ack); end
            end
            commit();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive((c < 12) ? mkflit(1'b1, 32'h400 + c) : '0, '0, (c >= 2));
            n_cmp++; if (req0_ack !== e_a0) begin n_err++; $display("FAIL wrap_ack0 c=%0d got=%b exp=%b", c, req0_ack, e_a0); end
            n_cmp++; if (bnd_flit !== e_flit) begin n_err++; $display("FAIL wrap_flit c=%0d got=%h exp=%h", c, bnd_flit, e_flit); end
            n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL wrap_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
            if (c >= 2 && c < 12) begin
                n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL wrap_occ_steady c=%0d got=%0d exp=2", c, occupancy); end
            end
            commit();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(mkflit(1'b1, 32'h500 + c), '0, 1'b0);
            n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL mid_fill_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
            commit();
        end
        req0_flit = mkflit(1'b1, 32'h5a);
        req1_flit = mkflit(1'b1, 32'h5b);
        bnd_ready = 1'b1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bnd_flit !== '0) begin n_err++; $display("FAIL mid_rst_flit got=%h exp=0", bnd_flit); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL mid_rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (req0_ack !== 1'b0 || req1_ack !== 1'b0) begin n_err++; $display("FAIL mid_rst_ack got=%b%b exp=00", req0_ack, req1_ack); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_lg = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(mkflit(1'b1, 32'h600 + c), mkflit(1'b1, 32'h700 + c), 1'b1);
            if (c == 0) begin
                n_cmp++; if (req0_ack !== 1'b1) begin n_err++; $display("FAIL mid_first_grant got=%b exp=1", req0_ack); end
            end
            n_cmp++; if (req0_ack !== e_a0) begin n_err++; $display("FAIL mid_ack0 c=%0d got=%b exp=%b", c, req0_ack, e_a0); end
            n_cmp++; if (req1_ack !== e_a1) begin n_err++; $display("FAIL mid_ack1 c=%0d got=%b exp=%b", c, req1_ack, e_a1); end
            n_cmp++; if (bnd_flit !== e_flit) begin n_err++; $display("FAIL mid_flit c=%0d got=%h exp=%h", c, bnd_flit, e_flit); end
            commit();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 60; c++) begin
            drive(mkflit(1'($urandom_range(0, 1)), $urandom), mkflit(1'($urandom_range(0, 1)), $urandom),
                  1'($urandom_range(0, 2) != 0));
            n_cmp++; if (req0_ack !== e_a0) begin n_err++; $display("FAIL rnd_ack0 c=%0d got=%b exp=%b", c, req0_ack, e_a0); end
            n_cmp++; if (req1_ack !== e_a1) begin n_err++; $display("FAIL rnd_ack1 c=%0d got=%b exp=%b", c, req1_ack, e_a1); end
            n_cmp++; if (bnd_flit !== e_flit) begin n_err++; $display("FAIL rnd_flit c=%0d got=%h exp=%h", c, bnd_flit, e_flit); end
            n_cmp++; if (occupancy !== e_occ) begin n_err++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
            commit();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_lg = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
